// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared defines for the instruction fetch block.
//   ADDR_W / INST_W : address and instruction widths (32 bits)
//   fetch_state_e   : fetch FSM encoding (IDLE, FILL)
//   word_align()    : clears the byte-offset bits of a fetch address
package inst_fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_byte_asm.sv
// fetch_byte_asm: 2-bit byte counter plus little-endian word assembler
// used while a missed word is filled one byte at a time.
//   clk, rst   : clock, synchronous active-low reset
//   clr        : restart assembly (counter and partial word to 0)
//   en         : accept byte_i into lane cnt and advance the counter
//   byte_i     : incoming byte
//   cnt        : current byte lane (0..3)
//   last       : cnt == 3, the next accepted byte completes the word
//   word_nxt   : partial word with byte_i merged into lane cnt
module fetch_byte_asm
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        byte_i,
  output logic [1:0]        cnt,
  output logic              last,
  output logic [INST_W-1:0] word_nxt
);
  logic [INST_W-1:0] word;

  // Merge is combinational so the final byte can be delivered in the
  // same edge that accepts it, without a bubble cycle.
  always_comb begin
    word_nxt = word;
    word_nxt[{cnt, 3'b000} +: 8] = byte_i;
  end

  assign last = (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= 2'd0;
      word <= '0;
    end else if (clr) begin
      cnt  <= 2'd0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= word_nxt;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Looks up the word-aligned PC in the
// icache; on a miss it reads the word from byte-wide memory (4 acked bytes,
// little-endian), writes it to the cache and delivers it.
// Build option: define INST_FETCH_CACHE_EN to use icache hits; without it
// icache_hit_i is ignored, icache_we_o is 0 and every fetch goes through FILL.
//   clk, rst, rdy        : clock, sync active-low reset, global ready (hold)
//   pc_i, req_i, flush_i : fetch address, fetch request, branch flush
//   icache_*             : lookup address, hit/data, fill write data/strobe
//   mem_*                : byte read request/address, returned byte/ack
//   inst_*               : delivered instruction, its PC, one-cycle strobe
//   stall_o              : fetch busy, PC stage holds
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              req_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] icache_addr_o,
  input  logic [INST_W-1:0] icache_data_i,
  input  logic              icache_hit_i,
  output logic [INST_W-1:0] icache_wdata_o,
  output logic              icache_we_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_byte_i,
  input  logic              mem_ack_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              stall_o
);
  fetch_state_e      state;
  logic [ADDR_W-1:0] pc_aligned, fetch_addr;
  logic              hit_eff, we_q;
  logic [1:0]        cnt;
  logic              last;
  logic [INST_W-1:0] word_nxt;

`ifdef INST_FETCH_CACHE_EN
  localparam logic CACHE_EN = 1'b1;
  assign hit_eff = icache_hit_i;
`else
  localparam logic CACHE_EN = 1'b0;
  logic unused_hit;
  assign hit_eff    = 1'b0;
  assign unused_hit = icache_hit_i;
`endif

  assign pc_aligned    = word_align(pc_i);
  assign icache_addr_o = (state == FILL) ? fetch_addr : pc_aligned;
  assign mem_addr_o    = fetch_addr + ADDR_W'(cnt);
  assign icache_we_o   = we_q;
  assign stall_o       = (state == FILL) | ((state == IDLE) & req_i & ~hit_eff);

  // Counter/assembler only move on rdy so a stalled pipeline drops acks.
  fetch_byte_asm u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (rdy & (state == IDLE) & req_i & ~flush_i & ~hit_eff),
    .en       (rdy & (state == FILL) & ~flush_i & mem_ack_i),
    .byte_i   (mem_byte_i),
    .cnt      (cnt),
    .last     (last),
    .word_nxt (word_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      fetch_addr     <= '0;
      inst_o         <= '0;
      inst_pc_o      <= RESET_PC;
      inst_valid_o   <= 1'b0;
      we_q           <= 1'b0;
      icache_wdata_o <= '0;
      mem_req_o      <= 1'b0;
    end else if (rdy) begin
      inst_valid_o <= 1'b0;
      we_q         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i && !flush_i) begin
            if (hit_eff) begin
              inst_o       <= icache_data_i;
              inst_pc_o    <= pc_aligned;
              inst_valid_o <= 1'b1;
            end else begin
              fetch_addr <= pc_aligned;
              mem_req_o  <= 1'b1;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          // Flush wins over a simultaneous final ack: the word is dropped.
          if (flush_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
          end else if (mem_ack_i && last) begin
            state          <= IDLE;
            mem_req_o      <= 1'b0;
            we_q           <= CACHE_EN;
            icache_wdata_o <= word_nxt;
            inst_o         <= word_nxt;
            inst_pc_o      <= fetch_addr;
            inst_valid_o   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model (pending fetch + byte queue).
module tb_inst_fetch;
  localparam logic [31:0] RPC = 32'h0000_1000;
`ifdef INST_FETCH_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, req_i, flush_i, icache_hit_i, mem_ack_i;
  logic [31:0] pc_i, icache_data_i;
  logic [7:0]  mem_byte_i;
  logic [31:0] icache_addr_o, icache_wdata_o, mem_addr_o, inst_o, inst_pc_o;
  logic        icache_we_o, mem_req_o, inst_valid_o, stall_o;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .req_i(req_i), .flush_i(flush_i),
    .icache_addr_o(icache_addr_o), .icache_data_i(icache_data_i),
    .icache_hit_i(icache_hit_i), .icache_wdata_o(icache_wdata_o),
    .icache_we_o(icache_we_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_byte_i(mem_byte_i), .mem_ack_i(mem_ack_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .stall_o(stall_o)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: a pending fetch is an address plus the bytes received so far.
  bit          m_known = 0, m_busy, m_valid, m_we;
  logic [31:0] m_faddr, m_inst, m_pc, m_wdata;
  logic [7:0]  m_bytes[$];

  function automatic logic [31:0] aln(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic model_edge();
    logic [31:0] w;
    if (!rst) begin
      m_known = 1; m_busy = 0; m_valid = 0; m_we = 0;
      m_inst = 0; m_pc = RPC; m_wdata = 0; m_bytes.delete();
    end else if (rdy) begin
      m_valid = 0; m_we = 0;
      if (!m_busy) begin
        if (req_i && !flush_i) begin
          if (CACHE_EN && icache_hit_i) begin
            m_inst = icache_data_i; m_pc = aln(pc_i); m_valid = 1;
          end else begin
            m_busy = 1; m_faddr = aln(pc_i); m_bytes.delete();
          end
        end
      end else if (flush_i) begin
        m_busy = 0; m_bytes.delete();
      end else if (mem_ack_i) begin
        m_bytes.push_back(mem_byte_i);
        if (m_bytes.size() == 4) begin
          w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_busy = 0; m_bytes.delete();
          m_valid = 1; m_inst = w; m_pc = m_faddr;
          m_we = CACHE_EN; m_wdata = w;
        end
      end
    end
  endtask

  task automatic check_outputs();
    if (!m_known) return;
    chk("inst_valid", 32'(inst_valid_o), 32'(m_valid));
    chk("icache_we", 32'(icache_we_o), 32'(m_we));
    chk("mem_req", 32'(mem_req_o), 32'(m_busy));
    chk("inst", inst_o, m_inst);
    chk("inst_pc", inst_pc_o, m_pc);
    chk("stall", 32'(stall_o), 32'(m_busy | (req_i & ~(CACHE_EN & icache_hit_i))));
    chk("icache_addr", icache_addr_o, m_busy ? m_faddr : aln(pc_i));
    if (m_we) chk("icache_wdata", icache_wdata_o, m_wdata);
    if (m_busy) chk("mem_addr", mem_addr_o, m_faddr + 32'(m_bytes.size()));
  endtask

  // One clock: drive at negedge, check after settle, then advance model.
  task automatic cyc(input logic r, input logic y, input logic [31:0] pc,
                     input logic q, input logic f, input logic h,
                     input logic [31:0] d, input logic [7:0] b, input logic a);
    @(negedge clk);
    rst = r; rdy = y; pc_i = pc; req_i = q; flush_i = f;
    icache_hit_i = h; icache_data_i = d; mem_byte_i = b; mem_ack_i = a;
    #1 check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic bytes4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 0, w[8*i +: 8], 1);
  endtask

  initial begin
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("reset_pc", inst_pc_o, RPC);
    chk("reset_valid", 32'(inst_valid_o), 0);
    idle(1);

    // Hit at 0x104 (a fill in the cache-less build).
    cyc(1, 1, 32'h104, 1, 0, 1, 32'h00A00093, 0, 0);
    #1 chk("hit_path_valid", 32'(inst_valid_o), 32'(CACHE_EN));
    if (!CACHE_EN) bytes4(32'h11223344);
    idle(2);

    // Miss at 0x200, bytes 13 05 10 00.
    cyc(1, 1, 32'h202, 1, 0, 0, 0, 0, 0);
    bytes4(32'h00100513);
    #1 chk("miss_inst", inst_o, 32'h00100513);
    chk("miss_pc", inst_pc_o, 32'h200);
    chk("miss_we", 32'(icache_we_o), 32'(CACHE_EN));
    idle(2);

    // Flush on the second ack.
    cyc(1, 1, 32'h300, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 8'hAA, 1);
    cyc(1, 1, 0, 0, 1, 0, 0, 8'hBB, 1);
    #1 chk("flush_req", 32'(mem_req_o), 0);
    idle(3);

    // Flush together with the final ack.
    cyc(1, 1, 32'h380, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 8'h5A, 1);
    cyc(1, 1, 0, 0, 1, 0, 0, 8'h5A, 1);
    idle(2);

    // rdy low for 3 cycles mid-fill with acks present.
    cyc(1, 1, 32'h400, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 8'h78, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 8'h56, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 8'hEE, 1);
    #1 chk("rdy_hold_addr", mem_addr_o, 32'h402);
    cyc(1, 1, 0, 0, 0, 0, 0, 8'h34, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 8'h12, 1);
    #1 chk("rdy_inst", inst_o, 32'h12345678);
    idle(2);

    // Reset mid-fill.
    cyc(1, 1, 32'h500, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 8'h01, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h02, 1);
    #1 chk("rst_mid_pc", inst_pc_o, RPC);
    chk("rst_mid_req", 32'(mem_req_o), 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(199) != 0), ($urandom_range(9) < 8), $urandom,
          $urandom_range(1), ($urandom_range(9) == 0), $urandom_range(1),
          $urandom, 8'($urandom), ($urandom_range(9) < 6));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, value of inst_pc_o after reset.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port rdy, input, 1, global ready; when low, all registers hold.
REQ-005 SHALL have ports pc_i (input, 32, fetch address) and req_i (input, 1, fetch request).
REQ-006 SHALL have port flush_i, input, 1, branch flush that aborts the fetch in progress.
REQ-007 SHALL have ports icache_addr_o (output, 32, lookup/write address), icache_data_i (input, 32, cached word) and icache_hit_i (input, 1, tag hit, combinational on icache_addr_o).
REQ-008 SHALL have ports icache_wdata_o (output, 32, fill word) and icache_we_o (output, 1, one-cycle cache write strobe).
REQ-009 SHALL have ports mem_req_o (output, 1, byte read request), mem_addr_o (output, 32, byte address), mem_byte_i (input, 8, returned byte) and mem_ack_i (input, 1, mem_byte_i valid this cycle).
REQ-010 SHALL have ports inst_o (output, 32, instruction), inst_pc_o (output, 32, its address) and inst_valid_o (output, 1, one-cycle delivery strobe).
REQ-011 SHALL have port stall_o, output, 1, fetch busy; the PC stage holds while it is high.

Function
REQ-012 SHALL word-align every fetch: fetch address = {pc_i[31:2],2'b00}.
REQ-013 SHALL drive icache_addr_o combinationally from the aligned pc_i in IDLE and from the latched fetch address in FILL.
REQ-014 SHALL use FSM states IDLE and FILL only.
REQ-015 SHALL, in IDLE with rdy=1, req_i=1, flush_i=0 and icache_hit_i=1, register inst_o=icache_data_i, inst_pc_o=aligned address and inst_valid_o=1 for the next cycle (hit latency 1), remaining in IDLE.
REQ-016 SHALL, in IDLE with rdy=1, req_i=1, flush_i=0 and icache_hit_i=0, latch the aligned address, clear the 2-bit byte counter and enter FILL.
REQ-017 SHALL hold mem_req_o=1 and mem_addr_o=latched address+counter in FILL.
REQ-018 SHALL, on each FILL cycle with mem_ack_i=1, store mem_byte_i in bits [8*cnt+7:8*cnt] (little-endian) and increment the counter.
REQ-019 SHALL, on the ack with cnt=3, return to IDLE and for exactly the next cycle assert icache_we_o=1 with icache_wdata_o=assembled word and inst_valid_o=1 with inst_o equal to the same word.
REQ-020 SHALL drive stall_o = (state==FILL) | (state==IDLE & req_i & ~icache_hit_i), combinationally.
REQ-021 SHALL, on flush_i=1 in FILL, including in the same cycle as the final ack, return to IDLE, discard the partial word and emit neither icache_we_o nor inst_valid_o.
REQ-022 SHALL ignore req_i and flush_i in IDLE when flush_i=1 (no acceptance that cycle).
REQ-023 SHALL, when rdy=0, change no register; mem_acks arriving while rdy=0 are ignored.
REQ-024 SHALL keep inst_valid_o and icache_we_o low in every cycle not named in REQ-015/REQ-019.

Reset
REQ-025 SHALL, on rst=0 at a clock edge, set state=IDLE, counter=0, inst_valid_o=0, icache_we_o=0, mem_req_o=0, inst_o=0, icache_wdata_o=0 and inst_pc_o=RESET_PC.
REQ-026 SHALL abandon any in-progress FILL on reset, with no cache write.

Configuration
REQ-027 SHALL, with macro INST_FETCH_CACHE_EN defined, behave as REQ-015 to REQ-019.
REQ-028 SHALL, without INST_FETCH_CACHE_EN, treat icache_hit_i as 0, tie icache_we_o to 0 and fetch every instruction through FILL.

Structure
REQ-029 SHALL take the FSM state encoding and the 32-bit address/instruction widths from the shared defines package.
REQ-030 SHALL contain one sub-module, fetch_byte_asm (byte counter plus word assembler); the FSM remains in inst_fetch.

Verification
REQ-031 SHALL cover a hit: pc_i=0x104, icache_hit_i=1, icache_data_i=0x00A00093 -> next cycle inst_valid_o=1, inst_o=0x00A00093, inst_pc_o=0x104, mem_req_o=0.
REQ-032 SHALL cover a miss: pc_i=0x200, memory bytes 13,05,10,00 acked on 4 cycles -> mem_addr_o=0x200..0x203 in turn, then one cycle with icache_we_o=1, inst_o=0x00100513.
REQ-033 SHALL cover flush: flush_i=1 during the second ack of a fill -> IDLE next cycle, no icache_we_o, no inst_valid_o.
REQ-034 SHALL cover rdy=0 for 3 cycles mid-fill -> counter and mem_addr_o unchanged, and the fill completes correctly after rdy returns high.
REQ-035 SHALL cover reset: rst=0 asserted mid-fill -> all outputs at reset values next cycle, inst_pc_o=RESET_PC.
REQ-036 SHALL cover a build without INST_FETCH_CACHE_EN: icache_hit_i=1 -> fill still performed and icache_we_o stays 0.
